// File: rtl/memory_pkg.sv
// Shared types and default parameter values for the memory_param block.
package memory_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH     = 8;
  localparam int DEFAULT_DEPTH     = 8;
  localparam bit DEFAULT_BYPASS    = 1'b0;
  localparam int DEFAULT_CLEAR_VAL = 0;

endpackage

// File: rtl/memory_param.sv
// Parameterised single-clock register-array memory with a post-reset clear sweep,
// one-cycle registered read, optional write-to-read bypass and range-error flag.
module memory_param
  import memory_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter int               DEPTH     = DEFAULT_DEPTH,
  parameter bit               BYPASS    = DEFAULT_BYPASS,
  parameter logic [WIDTH-1:0] CLEAR_VAL = WIDTH'(DEFAULT_CLEAR_VAL),
  localparam int              AW        = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             write,
  input  logic [AW-1:0]    addr_w,
  input  logic [WIDTH-1:0] datain,
  input  logic             read,
  input  logic [AW-1:0]    addr_r,
  output logic [WIDTH-1:0] dataout,
  output logic             rvalid,
  output logic             ready,
  output logic             err
);

  // Address checks use one extra bit so DEPTH itself is representable.
  localparam logic [AW:0] LIMIT   = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST    = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];

  state_t      state;
  logic [AW:0] ptr;

  logic             accept;
  logic             w_ok;
  logic             r_ok;
  logic             w_bad;
  logic             r_bad;
  logic             same_addr;
  logic             mem_we;
  logic [AW-1:0]    mem_wa;
  logic [WIDTH-1:0] mem_wd;

  // The single write port is shared between the clear sweep and user writes.
  always_comb begin
    accept    = (state == READY);
    w_ok      = ({1'b0, addr_w} < LIMIT);
    r_ok      = ({1'b0, addr_r} < LIMIT);
    w_bad     = accept && write && !w_ok;
    r_bad     = accept && read && !r_ok;
    same_addr = write && w_ok && (addr_w == addr_r);
    mem_we    = 1'b0;
    mem_wa    = addr_w;
    mem_wd    = datain;
    if (reset_n) begin
      if (state == CLEAR) begin
        mem_we = 1'b1;
        mem_wa = ptr[AW-1:0];
        mem_wd = CLEAR_VAL;
      end else if (write && w_ok) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= CLEAR;
      ptr     <= '0;
      ready   <= 1'b0;
      dataout <= '0;
      rvalid  <= 1'b0;
      err     <= 1'b0;
    end else begin
      err    <= w_bad || r_bad;
      rvalid <= accept && read;
      unique case (state)
        CLEAR: begin
          ptr <= ptr + PTR_ONE;
          if (ptr == LAST) begin
            state <= READY;
            ready <= 1'b1;
          end
        end
        READY: begin
          // Bypass only matters when the write is in range and hits the read address.
          if (read) begin
            if (!r_ok) begin
              dataout <= '0;
            end else if (BYPASS && same_addr) begin
              dataout <= datain;
            end else begin
              dataout <= mem[addr_r];
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_param.sv
// Self-checking bench for memory_param: three instances (8x8 no bypass, 8x6 bypass,
// 32x16) driven by directed and randomized stimulus against a behavioural model.
module tb_memory_param;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst_n;

  logic       wr0, rd0, rv0, rdy0, er0;
  logic [2:0] aw0, ar0;
  logic [7:0] di0, do0;

  logic       wr1, rd1, rv1, rdy1, er1;
  logic [2:0] aw1, ar1;
  logic [7:0] di1, do1;

  logic        wr2, rd2, rv2, rdy2, er2;
  logic [3:0]  aw2, ar2;
  logic [31:0] di2, do2;

  int errors = 0;
  int checks = 0;

  localparam logic [7:0]  CV0 = 8'hA5;
  localparam logic [7:0]  CV1 = 8'h3C;
  localparam logic [31:0] CV2 = 32'h0BAD_F00D;

  memory_param #(.WIDTH(8), .DEPTH(8), .BYPASS(1'b0), .CLEAR_VAL(CV0)) dut0 (
    .clock(clock), .reset_n(rst_n), .write(wr0), .addr_w(aw0), .datain(di0),
    .read(rd0), .addr_r(ar0), .dataout(do0), .rvalid(rv0), .ready(rdy0), .err(er0)
  );

  memory_param #(.WIDTH(8), .DEPTH(6), .BYPASS(1'b1), .CLEAR_VAL(CV1)) dut1 (
    .clock(clock), .reset_n(rst_n), .write(wr1), .addr_w(aw1), .datain(di1),
    .read(rd1), .addr_r(ar1), .dataout(do1), .rvalid(rv1), .ready(rdy1), .err(er1)
  );

  memory_param #(.WIDTH(32), .DEPTH(16), .BYPASS(1'b0), .CLEAR_VAL(CV2)) dut2 (
    .clock(clock), .reset_n(rst_n), .write(wr2), .addr_w(aw2), .datain(di2),
    .read(rd2), .addr_r(ar2), .dataout(do2), .rvalid(rv2), .ready(rdy2), .err(er2)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_all();
    wr0 = 1'b0; rd0 = 1'b0; aw0 = '0; ar0 = '0; di0 = '0;
    wr1 = 1'b0; rd1 = 1'b0; aw1 = '0; ar1 = '0; di1 = '0;
    wr2 = 1'b0; rd2 = 1'b0; aw2 = '0; ar2 = '0; di2 = '0;
  endtask

  // Resets all instances, optionally re-asserts reset after glitch_at sweep
  // cycles, then measures how many cycles each instance needs to become ready.
  task automatic reset_and_sweep(input bit noisy, input int glitch_at);
    int  r0, r1, r2;
    bit  quiet_bad;
    idle_all();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    if (glitch_at > 0) begin
      repeat (glitch_at) tick();
      rst_n = 1'b0;
      tick();
      checks++;
      if ({rdy0, rdy1, rdy2} !== 3'b000) begin
        errors++;
        $display("[TB] FAIL glitch_ready: got %b expected 000", {rdy0, rdy1, rdy2});
      end
      rst_n = 1'b1;
    end
    r0 = 0; r1 = 0; r2 = 0;
    quiet_bad = 1'b0;
    for (int k = 1; k <= 40 && r2 == 0; k++) begin
      if (noisy && k <= 5) begin
        wr0 = 1'b1; aw0 = 3'd1; di0 = 8'hEE; rd0 = 1'b1; ar0 = 3'd1;
        wr1 = 1'b1; aw1 = 3'd2; di1 = 8'h11; rd1 = 1'b1; ar1 = 3'd7;
        wr2 = 1'b1; aw2 = 4'd3; di2 = 32'hDEAD_BEEF; rd2 = 1'b1; ar2 = 4'd3;
      end else begin
        idle_all();
      end
      tick();
      if (rdy0 === 1'b1 && r0 == 0) r0 = k;
      if (rdy1 === 1'b1 && r1 == 0) r1 = k;
      if (rdy2 === 1'b1 && r2 == 0) r2 = k;
      if ({rv0, er0, rv1, er1, rv2, er2} !== 6'b0) quiet_bad = 1'b1;
    end
    idle_all();
    checks++;
    if (r0 != 8) begin
      errors++;
      $display("[TB] FAIL sweep_len0: got %0d expected 8", r0);
    end
    checks++;
    if (r1 != 6) begin
      errors++;
      $display("[TB] FAIL sweep_len1: got %0d expected 6", r1);
    end
    checks++;
    if (r2 != 16) begin
      errors++;
      $display("[TB] FAIL sweep_len2: got %0d expected 16", r2);
    end
    checks++;
    if (quiet_bad) begin
      errors++;
      $display("[TB] FAIL clear_quiet: got rvalid/err activity expected none");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wr0 = 1'b1; aw0 = 3'd4; di0 = 8'h44; rd0 = 1'b1; ar0 = 3'd4;
    tick();
    checks++;
    if ({rdy0, rv0, er0, do0} !== 11'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs0: got %b expected all zero", {rdy0, rv0, er0, do0});
    end
    checks++;
    if ({rdy1, rv1, er1, do1, rdy2, rv2, er2, do2} !== 46'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs12: got %h expected 0", {rdy1, rv1, er1, do1, rdy2, rv2, er2, do2});
    end
    reset_and_sweep(1'b1, 0);
    checks++;
    if ({do0, do1, do2} !== 48'b0) begin
      errors++;
      $display("[TB] FAIL dataout_after_sweep: got %h expected 0", {do0, do1, do2});
    end
  endtask

  task automatic test_clear_values();
    for (int i = 0; i < 17; i++) begin
      rd0 = (i < 8);  ar0 = 3'(i);
      rd1 = (i < 6);  ar1 = 3'(i);
      rd2 = (i < 16); ar2 = 4'(i);
      tick();
      if (i < 8) begin
        checks++;
        if (rv0 !== 1'b1 || do0 !== CV0) begin
          errors++;
          $display("[TB] FAIL clear_read0[%0d]: got rv=%b %h expected rv=1 %h", i, rv0, do0, CV0);
        end
      end else if (i == 8) begin
        checks++;
        if (rv0 !== 1'b0 || do0 !== CV0) begin
          errors++;
          $display("[TB] FAIL hold0: got rv=%b %h expected rv=0 %h", rv0, do0, CV0);
        end
      end
      if (i < 6) begin
        checks++;
        if (rv1 !== 1'b1 || do1 !== CV1) begin
          errors++;
          $display("[TB] FAIL clear_read1[%0d]: got rv=%b %h expected rv=1 %h", i, rv1, do1, CV1);
        end
      end
      if (i < 16) begin
        checks++;
        if (rv2 !== 1'b1 || do2 !== CV2) begin
          errors++;
          $display("[TB] FAIL clear_read2[%0d]: got rv=%b %h expected rv=1 %h", i, rv2, do2, CV2);
        end
      end
    end
    idle_all();
  endtask

  task automatic test_write_read();
    wr0 = 1'b1; aw0 = 3'd5; di0 = 8'h05;
    tick();
    wr0 = 1'b0;
    checks++;
    if (rv0 !== 1'b0 || er0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL write_only_flags: got rv=%b err=%b expected 0 0", rv0, er0);
    end
    rd0 = 1'b1; ar0 = 3'd5;
    tick();
    rd0 = 1'b0;
    checks++;
    if (rv0 !== 1'b1 || do0 !== 8'h05) begin
      errors++;
      $display("[TB] FAIL write_then_read: got rv=%b %h expected rv=1 05", rv0, do0);
    end
  endtask

  task automatic test_bypass();
    wr1 = 1'b1; aw1 = 3'd5; di1 = 8'h05;
    tick();
    wr0 = 1'b1; aw0 = 3'd5; di0 = 8'h08; rd0 = 1'b1; ar0 = 3'd5;
    wr1 = 1'b1; aw1 = 3'd5; di1 = 8'h08; rd1 = 1'b1; ar1 = 3'd5;
    tick();
    wr0 = 1'b0; wr1 = 1'b0;
    checks++;
    if (rv0 !== 1'b1 || do0 !== 8'h05) begin
      errors++;
      $display("[TB] FAIL rdw_old_data: got rv=%b %h expected rv=1 05", rv0, do0);
    end
    checks++;
    if (rv1 !== 1'b1 || do1 !== 8'h08) begin
      errors++;
      $display("[TB] FAIL rdw_bypass: got rv=%b %h expected rv=1 08", rv1, do1);
    end
    tick();
    rd0 = 1'b0; rd1 = 1'b0;
    checks++;
    if (do0 !== 8'h08 || do1 !== 8'h08) begin
      errors++;
      $display("[TB] FAIL rdw_write_done: got %h %h expected 08 08", do0, do1);
    end
  endtask

  task automatic test_out_of_range();
    logic [7:0] exp;
    wr1 = 1'b1; aw1 = 3'd7; di1 = 8'h77;
    tick();
    wr1 = 1'b0;
    checks++;
    if (er1 !== 1'b1 || rv1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL oor_write_err: got err=%b rv=%b expected 1 0", er1, rv1);
    end
    tick();
    checks++;
    if (er1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_pulse_len: got %b expected 0", er1);
    end
    for (int i = 0; i < 6; i++) begin
      rd1 = 1'b1; ar1 = 3'(i);
      tick();
      exp = (i == 5) ? 8'h08 : CV1;
      checks++;
      if (do1 !== exp || er1 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL oor_untouched[%0d]: got %h err=%b expected %h err=0", i, do1, er1, exp);
      end
    end
    ar1 = 3'd6;
    tick();
    rd1 = 1'b0;
    checks++;
    if (do1 !== 8'h00 || rv1 !== 1'b1 || er1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL oor_read: got %h rv=%b err=%b expected 00 1 1", do1, rv1, er1);
    end
    wr1 = 1'b1; aw1 = 3'd6; di1 = 8'h66; rd1 = 1'b1; ar1 = 3'd6;
    tick();
    wr1 = 1'b0; rd1 = 1'b0;
    checks++;
    if (do1 !== 8'h00 || er1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL oor_both: got %h err=%b expected 00 1", do1, er1);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [16];
    for (int i = 0; i < 16; i++) begin
      vals[i] = ($urandom & 32'hFFFF_FFF0) | 32'(i);
      wr2 = 1'b1; aw2 = 4'(i); di2 = vals[i];
      tick();
    end
    wr2 = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      rd2 = 1'b1; ar2 = 4'(i);
      tick();
      checks++;
      if (rv2 !== 1'b1 || do2 !== vals[i]) begin
        errors++;
        $display("[TB] FAIL b2b_read[%0d]: got rv=%b %h expected rv=1 %h", i, rv2, do2, vals[i]);
      end
    end
    rd2 = 1'b0;
    tick();
    checks++;
    if (rv2 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_rvalid_drop: got %b expected 0", rv2);
    end
  endtask

  task automatic test_reset_mid_sweep();
    rd0 = 1'b1; ar0 = 3'd5;
    rst_n = 1'b0;
    tick();
    checks++;
    if (rv0 !== 1'b0 || do0 !== 8'h00 || rdy0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_discard: got rv=%b %h rdy=%b expected 0 00 0", rv0, do0, rdy0);
    end
    reset_and_sweep(1'b1, 3);
    for (int i = 0; i < 8; i++) begin
      rd0 = 1'b1; ar0 = 3'(i);
      tick();
      checks++;
      if (do0 !== CV0) begin
        errors++;
        $display("[TB] FAIL resweep_value[%0d]: got %h expected %h", i, do0, CV0);
      end
    end
    rd0 = 1'b0;
  endtask

  // Reference behaviour: array contents plus the last value a read produced.
  task automatic test_random();
    logic [7:0] m0 [8];
    logic [7:0] m1 [6];
    logic [7:0] e_do0, e_do1;
    logic       e_rv0, e_rv1, e_er0, e_er1;
    int         a_w, a_r;
    reset_and_sweep(1'b0, 0);
    for (int i = 0; i < 8; i++) m0[i] = CV0;
    for (int i = 0; i < 6; i++) m1[i] = CV1;
    e_do0 = 8'h00;
    e_do1 = 8'h00;
    for (int n = 0; n < 300; n++) begin
      wr0 = 1'($urandom); rd0 = 1'($urandom); di0 = 8'($urandom);
      aw0 = 3'($urandom_range(0, 7));
      ar0 = ($urandom_range(0, 3) == 0) ? aw0 : 3'($urandom_range(0, 7));
      wr1 = 1'($urandom); rd1 = 1'($urandom); di1 = 8'($urandom);
      aw1 = 3'($urandom_range(0, 7));
      ar1 = ($urandom_range(0, 3) == 0) ? aw1 : 3'($urandom_range(0, 7));

      a_w = int'(aw0); a_r = int'(ar0);
      e_rv0 = rd0;
      e_er0 = 1'b0;
      if (rd0) e_do0 = m0[a_r];
      if (wr0) m0[a_w] = di0;

      a_w = int'(aw1); a_r = int'(ar1);
      e_rv1 = rd1;
      e_er1 = (wr1 && a_w >= 6) || (rd1 && a_r >= 6);
      if (rd1) begin
        if (a_r >= 6) e_do1 = 8'h00;
        else if (wr1 && a_w == a_r) e_do1 = di1;
        else e_do1 = m1[a_r];
      end
      if (wr1 && a_w < 6) m1[a_w] = di1;

      tick();
      checks++;
      if (do0 !== e_do0 || rv0 !== e_rv0 || er0 !== e_er0) begin
        errors++;
        $display("[TB] FAIL rand0[%0d]: got %h rv=%b err=%b expected %h rv=%b err=%b", n, do0, rv0, er0, e_do0, e_rv0, e_er0);
      end
      checks++;
      if (do1 !== e_do1 || rv1 !== e_rv1 || er1 !== e_er1) begin
        errors++;
        $display("[TB] FAIL rand1[%0d]: got %h rv=%b err=%b expected %h rv=%b err=%b", n, do1, rv1, er1, e_do1, e_rv1, e_er1);
      end
    end
    idle_all();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    idle_all();
    test_reset();
    test_clear_values();
    test_write_read();
    test_bypass();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_sweep();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_param.md
MEMORY_PARAM -- requirements
Module: memory_param

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 8, number of entries (>=2, need not be a power of two).
REQ-003 Parameter BYPASS, default 0: 1 = read-during-write to the same address returns new data, 0 = returns old data.
REQ-004 Parameter CLEAR_VAL, default 0, WIDTH-bit value written to every entry by the post-reset clear sweep.
REQ-005 Derived constant AW = max(1, clog2(DEPTH)), address width.
REQ-006 clock  input  1  sole clock, all state updates on rising edge.
REQ-007 reset_n  input  1  synchronous reset, active-low.
REQ-008 write  input  1  write request.
REQ-009 addr_w  input  AW  write address.
REQ-010 datain  input  WIDTH  write data.
REQ-011 read  input  1  read request.
REQ-012 addr_r  input  AW  read address.
REQ-013 dataout  output  WIDTH  registered read data.
REQ-014 rvalid  output  1  dataout updated by a read accepted the previous cycle.
REQ-015 ready  output  1  block accepts read/write requests (clear sweep complete).
REQ-016 err  output  1  one-cycle pulse: previous cycle had an out-of-range address on an accepted request.

Function
REQ-017 FSM states CLEAR and READY; reset forces CLEAR with sweep pointer 0.
REQ-018 CLEAR: each cycle write CLEAR_VAL to entry[pointer], increment pointer; after entry DEPTH-1 written, next state READY; sweep takes exactly DEPTH cycles after reset_n high.
REQ-019 ready = 1 only in READY; in CLEAR, write and read are ignored, rvalid and err stay 0.
REQ-020 READY, write=1, addr_w<DEPTH: entry[addr_w] <= datain at the rising edge.
REQ-021 READY, read=1, addr_r<DEPTH: dataout <= entry[addr_r] and rvalid <= 1 at the rising edge; latency one cycle.
REQ-022 read=0 or not ready: dataout holds its value, rvalid <= 0.
REQ-023 Simultaneous write and read to same valid address: BYPASS=1 -> dataout <= datain; BYPASS=0 -> dataout <= old entry; write always performed.
REQ-024 Simultaneous write and read to different addresses: both performed independently in the same cycle.
REQ-025 Address >= DEPTH on accepted write: no entry modified, err <= 1 next cycle.
REQ-026 Address >= DEPTH on accepted read: dataout <= 0, rvalid <= 1, err <= 1 next cycle.
REQ-027 err is the OR of both out-of-range conditions; otherwise err <= 0 each cycle.
REQ-028 Sweep pointer is AW+1 bits wide to avoid wrap when DEPTH is a power of two.

Reset
REQ-029 reset_n low at a rising edge: dataout <= 0, rvalid <= 0, err <= 0, ready <= 0, state CLEAR, pointer 0.
REQ-030 Memory contents are not reset directly; the CLEAR sweep initialises them.
REQ-031 Reset asserted mid-sweep or mid-operation restarts the sweep from entry 0; pending read result is discarded.

Structure
REQ-032 Shared package memory_pkg holds the FSM state enum (CLEAR, READY) and default parameter constants.
REQ-033 Single module, no sub-module; storage is a WIDTH x DEPTH register array inferable as distributed RAM.

Verification
REQ-034 Reset then release, WIDTH=8 DEPTH=8 CLEAR_VAL=8'hA5 -> ready low 8 cycles then high; reads of all 8 addresses return 8'hA5.
REQ-035 Write 8'h05 to addr 5, next cycle read addr 5 -> dataout 8'h05 with rvalid one cycle after read.
REQ-036 Same cycle write 8'h08 and read addr 5 (holding 8'h05): BYPASS=0 -> dataout 8'h05; BYPASS=1 -> 8'h08; subsequent read 8'h08 both cases.
REQ-037 DEPTH=6: write addr 7 -> err pulse, no entry changed; read addr 6 -> dataout 0, rvalid 1, err 1.
REQ-038 reset_n low for one cycle at sweep cycle 3 -> ready stays low full DEPTH cycles after release; reads/writes during CLEAR ignored.
REQ-039 WIDTH=32 DEPTH=16: write 16 distinct values, read back in reverse order -> every value matches, rvalid continuous during back-to-back reads.
